// File: rtl/vram_fetch_master.sv
// vram_fetch_master
// Read-only initiator on the VRAM bank port of the dual-bank SRAM controller.
// Fetches one screen cell pair (bitmap + attribute for columns x and x+1 on
// scanline y) as four strobed reads: bmp0, att0, bmp1, att1.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   fetch_req           start request, sampled only in IDLE
//   fetch_x[4:0]        first character column
//   fetch_y[7:0]        pixel line
//   busy                high while a fetch is in progress
//   fetch_done          one-cycle pulse, outputs updated in this cycle
//   bmp0/att0/bmp1/att1 fetched bytes, change only with fetch_done
//   a1[15:0]            bank address
//   cs1_n, oe1_n        bank strobes (identical, active low)
//   we1_n, din1         tied inactive (read-only master)
//   d1[7:0]             bank read data (registered in the controller)
module vram_fetch_master #(
  parameter logic [15:0] BASE        = 16'h4000,
  parameter int          WAIT_CYCLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_req,
  input  logic [4:0]  fetch_x,
  input  logic [7:0]  fetch_y,
  output logic        busy,
  output logic        fetch_done,
  output logic [7:0]  bmp0,
  output logic [7:0]  att0,
  output logic [7:0]  bmp1,
  output logic [7:0]  att1,
  output logic [15:0] a1,
  output logic        cs1_n,
  output logic        oe1_n,
  output logic        we1_n,
  output logic [7:0]  din1,
  input  logic [7:0]  d1
);

  typedef enum logic [1:0] {IDLE, ASSERT, CAPTURE, GAP} state_t;

  localparam logic [3:0] WLAST = 4'(WAIT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [1:0]  k;
  logic [3:0]  wcnt;
  logic [4:0]  xr;
  logic [7:0]  yr;
  logic [7:0]  hold0, hold1, hold2;

  // Slot 0/1 address column x, slots 2/3 column x+1 (5-bit wrap).
  // Even slots are bitmap, odd slots attribute.
  function automatic logic [15:0] slot_addr(input logic [1:0] s,
                                            input logic [4:0] x,
                                            input logic [7:0] y);
    logic [4:0] col;
    col = s[1] ? x + 5'd1 : x;
    if (s[0]) return {BASE[15:13], 3'b110, y[7:3], col};
    else      return {BASE[15:13], y[7:6], y[2:0], y[5:3], col};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_req) state_nxt = ASSERT;
      ASSERT:  if (wcnt == WLAST) state_nxt = CAPTURE;
      CAPTURE: state_nxt = GAP;
      GAP:     state_nxt = (k == 2'd3) ? IDLE : ASSERT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k     <= '0;
      wcnt  <= '0;
      xr    <= '0;
      yr    <= '0;
      a1    <= '0;
      hold0 <= '0;
      hold1 <= '0;
      hold2 <= '0;
      bmp0  <= '0;
      att0  <= '0;
      bmp1  <= '0;
      att1  <= '0;
    end else begin
      case (state)
        IDLE: if (fetch_req) begin
          xr   <= fetch_x;
          yr   <= fetch_y;
          k    <= 2'd0;
          wcnt <= '0;
          a1   <= slot_addr(2'd0, fetch_x, fetch_y);
        end
        ASSERT: wcnt <= wcnt + 4'd1;
        CAPTURE: begin
          wcnt <= '0;
          case (k)
            2'd0: hold0 <= d1;
            2'd1: hold1 <= d1;
            2'd2: hold2 <= d1;
            // Last slot bypasses its holding register so the whole set is
            // visible on the outputs in the fetch_done (GAP) cycle.
            default: begin
              bmp0 <= hold0;
              att0 <= hold1;
              bmp1 <= hold2;
              att1 <= d1;
            end
          endcase
        end
        GAP: if (k != 2'd3) begin
          k  <= k + 2'd1;
          a1 <= slot_addr(k + 2'd1, xr, yr);
        end
        default: ;
      endcase
    end
  end

  // Strobes decode straight from the state flop so reset raises them
  // asynchronously; CAPTURE+GAP give the 2-cycle high phase between reads.
  assign cs1_n      = (state != ASSERT);
  assign oe1_n      = (state != ASSERT);
  assign we1_n      = 1'b1;
  assign din1       = 8'h00;
  assign busy       = (state != IDLE);
  assign fetch_done = (state == GAP) && (k == 2'd3);

endmodule

// File: tb/tb_vram_fetch_master.sv
module tb_vram_fetch_master;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req = 1'b0;
  logic [4:0]  fetch_x = '0;
  logic [7:0]  fetch_y = '0;
  logic        busy, fetch_done;
  logic [7:0]  bmp0, att0, bmp1, att1;
  logic [15:0] a1;
  logic        cs1_n, oe1_n, we1_n;
  logic [7:0]  din1;
  logic [7:0]  d1 = 8'h00;

  vram_fetch_master #(.BASE(16'h4000), .WAIT_CYCLES(6)) dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .fetch_x(fetch_x),
    .fetch_y(fetch_y), .busy(busy), .fetch_done(fetch_done),
    .bmp0(bmp0), .att0(att0), .bmp1(bmp1), .att1(att1), .a1(a1),
    .cs1_n(cs1_n), .oe1_n(oe1_n), .we1_n(we1_n), .din1(din1), .d1(d1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: registered output, garbage at the start of an access,
  // addr[7:0]^A5 from the 4th edge after the falling strobe, held after.
  int lowcnt = 0;
  always @(posedge clk) begin
    if (cs1_n | oe1_n) lowcnt <= 0;
    else begin
      lowcnt <= lowcnt + 1;
      if (lowcnt == 0)      d1 <= 8'hEE;
      else if (lowcnt >= 3) d1 <= a1[7:0] ^ 8'hA5;
    end
  end

  // Strobe protocol monitor.
  logic        mon_en = 1'b1;
  logic        prev_s = 1'b1;
  logic [15:0] fall_a = '0;
  int falls = 0, lowlen = 0, hilen = 2, dones = 0;
  int low_err = 0, hi_err = 0, a1_err = 0, idle_err = 0, pair_err = 0;
  logic [15:0] addrq[$];

  always @(negedge clk) begin
    logic s;
    s = cs1_n | oe1_n;
    if (we1_n !== 1'b1 || din1 !== 8'h00) idle_err++;
    if (cs1_n !== oe1_n) pair_err++;
    if (fetch_done) dones++;
    if (mon_en) begin
      if (prev_s && !s) begin
        falls++; lowlen = 1; fall_a = a1; addrq.push_back(a1);
        if (hilen < 2) hi_err++;
      end else if (!s) begin
        lowlen++;
        if (a1 !== fall_a) a1_err++;
      end else if (!prev_s && s) begin
        if (lowlen != 6) low_err++;
        if (a1 !== fall_a) a1_err++;
        hilen = 1;
      end else hilen++;
    end
    prev_s = s;
  end

  int nvec = 0, nerr = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [4:0]       x;
    logic [7:0]       y;
    logic [3:0][15:0] addr;
    logic [3:0][7:0]  byt;
  } vec_t;

  function automatic vec_t mk(input logic [4:0] x, input logic [7:0] y,
                              input logic [15:0] a0, input logic [15:0] a1v,
                              input logic [15:0] a2, input logic [15:0] a3,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3);
    vec_t v;
    v.x = x; v.y = y;
    v.addr[0] = a0; v.addr[1] = a1v; v.addr[2] = a2; v.addr[3] = a3;
    v.byt[0] = b0; v.byt[1] = b1; v.byt[2] = b2; v.byt[3] = b3;
    return v;
  endfunction

  // Start at a negedge; drive request for one cycle; wait for fetch_done.
  task automatic do_fetch(input vec_t v, input string tag);
    int c0, n;
    @(negedge clk);
    addrq.delete();
    c0 = cyc;
    fetch_req = 1'b1; fetch_x = v.x; fetch_y = v.y;
    @(negedge clk);
    fetch_req = 1'b0;
    chk({tag, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!fetch_done && n < 100) begin @(negedge clk); n++; end
    chk({tag, " latency"}, 32'(cyc - c0), 32'd32);
    chk({tag, " bmp0"}, 32'(bmp0), 32'(v.byt[0]));
    chk({tag, " att0"}, 32'(att0), 32'(v.byt[1]));
    chk({tag, " bmp1"}, 32'(bmp1), 32'(v.byt[2]));
    chk({tag, " att1"}, 32'(att1), 32'(v.byt[3]));
    chk({tag, " nreads"}, 32'(addrq.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s addr%0d", tag, i),
          (i < addrq.size()) ? 32'(addrq[i]) : 32'hDEAD, 32'(v.addr[i]));
    @(negedge clk);
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " hold bmp1"}, 32'(bmp1), 32'(v.byt[2]));
  endtask

  vec_t vt[4];

  initial begin
    int c0, d0, f0, n;
    vt[0] = mk(5'd0,  8'd0,   16'h4000, 16'h5800, 16'h4001, 16'h5801, 8'hA5, 8'hA5, 8'hA4, 8'hA4);
    vt[1] = mk(5'd31, 8'd191, 16'h57FF, 16'h5AFF, 16'h57E0, 16'h5AE0, 8'h5A, 8'h5A, 8'h45, 8'h45);
    vt[2] = mk(5'd5,  8'h4D,  16'h4D25, 16'h5925, 16'h4D26, 16'h5926, 8'h80, 8'h80, 8'h83, 8'h83);
    vt[3] = mk(5'd16, 8'h80,  16'h5010, 16'h5A10, 16'h5011, 16'h5A11, 8'hB5, 8'hB5, 8'hB4, 8'hB4);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst cs1_n", 32'(cs1_n), 32'd1);
    chk("rst oe1_n", 32'(oe1_n), 32'd1);
    chk("rst a1", 32'(a1), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(fetch_done), 32'd0);
    chk("rst data", {bmp0, att0, bmp1, att1}, 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("post-rst busy", 32'(busy), 32'd0);
    chk("post-rst falls", 32'(falls), 32'd0);

    // Table-driven fetches
    for (int i = 0; i < 4; i++) do_fetch(vt[i], $sformatf("vec%0d", i));

    // Busy rejection: requests at 5 and 32 ignored, 33 accepted
    @(negedge clk);
    c0 = cyc; d0 = dones;
    fetch_req = 1'b1; fetch_x = 5'd3; fetch_y = 8'h10;
    for (n = 1; n <= 70; n++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      if (n == 31) chk("rej hold att1", 32'(att1), 32'hB4);
      if (n == 32) begin
        chk("rej done32", 32'(fetch_done), 32'd1);
        chk("rej busy32", 32'(busy), 32'd1);
        chk("rej bmp0", 32'(bmp0), 32'hE6);
        chk("rej att1", 32'(att1), 32'hE1);
      end
      if (n == 33) begin
        chk("rej busy33", 32'(busy), 32'd0);
        chk("rej cs33", 32'(cs1_n), 32'd1);
      end
      if (n == 34) chk("rej fall34", 32'(cs1_n), 32'd0);
      if (n == 65) begin
        chk("rej done65", 32'(fetch_done), 32'd1);
        chk("rej2 bmp0", 32'(bmp0), 32'hA2);
        chk("rej2 bmp1", 32'(bmp1), 32'hAD);
      end
      if (n == 5 || n == 32) begin fetch_req = 1'b1; fetch_x = 5'd9; fetch_y = 8'h55; end
      if (n == 33) begin fetch_req = 1'b1; fetch_x = 5'd7; fetch_y = 8'h00; end
    end
    chk("rej done count", 32'(dones - d0), 32'd2);

    // Back-to-back: 10 fetches with request held high
    @(negedge clk);
    c0 = cyc; f0 = falls; d0 = 0;
    fetch_req = 1'b1; fetch_x = 5'd1; fetch_y = 8'd2;
    n = 0;
    while (d0 < 10 && n < 600) begin
      @(negedge clk); n++;
      if (fetch_done) d0++;
      if (d0 == 10) fetch_req = 1'b0;
    end
    chk("b2b end cycle", 32'(cyc - c0), 32'd329);
    repeat (3) @(negedge clk);
    chk("b2b busy", 32'(busy), 32'd0);
    chk("b2b falls", 32'(falls - f0), 32'd40);

    // Reset mid-operation
    @(negedge clk);
    c0 = cyc; d0 = dones;
    fetch_req = 1'b1; fetch_x = vt[2].x; fetch_y = vt[2].y;
    @(negedge clk);
    fetch_req = 1'b0;
    while (cyc - c0 < 12) @(negedge clk);
    chk("mid strobe low", 32'(cs1_n), 32'd0);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid cs1_n", 32'(cs1_n), 32'd1);
    chk("mid oe1_n", 32'(oe1_n), 32'd1);
    chk("mid busy", 32'(busy), 32'd0);
    chk("mid a1", 32'(a1), 32'd0);
    chk("mid data", {bmp0, att0, bmp1, att1}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid no done", 32'(dones - d0), 32'd0);
    chk("mid data idle", {bmp0, att0, bmp1, att1}, 32'd0);
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    do_fetch(vt[3], "after-rst");

    // Global protocol checks
    chk("low phase len", 32'(low_err), 32'd0);
    chk("high phase len", 32'(hi_err), 32'd0);
    chk("a1 stable", 32'(a1_err), 32'd0);
    chk("we1_n/din1 idle", 32'(idle_err), 32'd0);
    chk("cs1_n==oe1_n", 32'(pair_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d miscompares so far", nerr);
    $fatal(1);
  end
endmodule
